// File: rtl/s_p_deserializer.sv
// Multi-lane serial-to-parallel converter with SYNC-based frame alignment,
// a valid/ready output register and a sticky overrun flag.
// All lanes share one bit counter and complete their words together.
module s_p_deserializer #(
   parameter int C_BITS_OUT  = 8,
   parameter int C_LANES     = 1,
   parameter int C_MSB_FIRST = 0
) (
   input  logic                            CK,
   input  logic                            RST,
   input  logic                            EN,
   input  logic                            SYNC,
   input  logic [C_LANES-1:0]              D,
   input  logic                            CLR_OVR,
   input  logic                            READY,
   output logic [C_LANES*C_BITS_OUT-1:0]   Q,
   output logic                            VALID,
   output logic                            LOCKED,
   output logic                            OVERRUN
);

   localparam int W  = C_BITS_OUT;
   localparam int QW = C_LANES * C_BITS_OUT;
   localparam int CW = (C_BITS_OUT > 1) ? $clog2(C_BITS_OUT) : 1;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(C_BITS_OUT - 1);

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_s;
   logic [QW-1:0]   sh_r;
   logic [QW-1:0]   sh_s;
   logic [QW-1:0]   q_r;
   logic [QW-1:0]   q_s;
   logic            valid_r;
   logic            valid_s;
   logic            locked_r;
   logic            locked_s;
   logic            ovr_r;
   logic            ovr_s;
   logic [QW-1:0]   shifted_s;
   logic [QW-1:0]   restart_s;
   logic            done_s;

   // Per-lane candidate register values: normal shift, and a fresh frame whose bit 0 is D.
   always_comb begin
      shifted_s = '0;
      restart_s = '0;
      for (int l = 0; l < C_LANES; l++) begin
         if (C_MSB_FIRST != 0) begin
            shifted_s[l*W +: W] = {sh_r[l*W +: W-1], D[l]};
            restart_s[l*W +: W] = {{(W-1){1'b0}}, D[l]};
         end else begin
            shifted_s[l*W +: W] = {D[l], sh_r[l*W+1 +: W-1]};
            restart_s[l*W +: W] = {D[l], {(W-1){1'b0}}};
         end
      end
   end

   // Alignment FSM: next state, bit counter, shift registers and word-completion strobe.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      sh_s    = sh_r;
      done_s  = 1'b0;
      case (state_r)
         ST_HUNT: begin
            if (EN && SYNC) begin
               state_s = ST_LOCK;
               sh_s    = restart_s;
               cnt_s   = CNT_ONE;
            end else begin
               state_s = ST_HUNT;
            end
         end
         ST_LOCK: begin
            if (EN && SYNC) begin
               // frame restart: partial word dropped, current bit is bit 0
               sh_s  = restart_s;
               cnt_s = CNT_ONE;
            end else if (EN) begin
               sh_s = shifted_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_s  = CNT_ZERO;
                  done_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else if (SYNC) begin
               // marker without a bit: drop the partial word, next bit is bit 0
               sh_s  = '0;
               cnt_s = CNT_ZERO;
            end else begin
               state_s = ST_LOCK;
            end
         end
         default: begin
            state_s = ST_HUNT;
            cnt_s   = CNT_ZERO;
            sh_s    = '0;
         end
      endcase
   end

   // Output register, handshake and sticky overrun (a new overrun beats a clear).
   always_comb begin
      q_s      = q_r;
      valid_s  = valid_r;
      locked_s = (state_s == ST_LOCK);
      if (CLR_OVR) begin
         ovr_s = 1'b0;
      end else begin
         ovr_s = ovr_r;
      end
      if (done_s) begin
         if (valid_r && !READY) begin
            ovr_s = 1'b1;
         end else begin
            q_s     = shifted_s;
            valid_s = 1'b1;
         end
      end else if (valid_r && READY) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_r  <= ST_HUNT;
         cnt_r    <= CNT_ZERO;
         sh_r     <= '0;
         q_r      <= '0;
         valid_r  <= 1'b0;
         locked_r <= 1'b0;
         ovr_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         sh_r     <= sh_s;
         q_r      <= q_s;
         valid_r  <= valid_s;
         locked_r <= locked_s;
         ovr_r    <= ovr_s;
      end
   end

   assign Q       = q_r;
   assign VALID   = valid_r;
   assign LOCKED  = locked_r;
   assign OVERRUN = ovr_r;

endmodule

// File: tb/tb_s_p_deserializer.sv
// Directed bench for s_p_deserializer: two 8-bit x 2-lane instances, one
// LSB-first and one MSB-first, driven with identical stimulus.
module tb_s_p_deserializer;

   logic        CK = 1'b0;
   logic        RST = 1'b0;
   logic        EN = 1'b0;
   logic        SYNC = 1'b0;
   logic        CLR_OVR = 1'b0;
   logic        READY = 1'b0;
   logic [1:0]  D = 2'b00;

   logic [15:0] q_l, q_m;
   logic        valid_l, valid_m, locked_l, locked_m, ovr_l, ovr_m;

   int total = 0;
   int bad   = 0;

   always #5 CK = ~CK;

   s_p_deserializer #(.C_BITS_OUT(8), .C_LANES(2), .C_MSB_FIRST(0)) dut_l (
      .CK(CK), .RST(RST), .EN(EN), .SYNC(SYNC), .D(D), .CLR_OVR(CLR_OVR),
      .READY(READY), .Q(q_l), .VALID(valid_l), .LOCKED(locked_l), .OVERRUN(ovr_l));

   s_p_deserializer #(.C_BITS_OUT(8), .C_LANES(2), .C_MSB_FIRST(1)) dut_m (
      .CK(CK), .RST(RST), .EN(EN), .SYNC(SYNC), .D(D), .CLR_OVR(CLR_OVR),
      .READY(READY), .Q(q_m), .VALID(valid_m), .LOCKED(locked_m), .OVERRUN(ovr_m));

   typedef struct {
      logic        en;
      logic        sync;
      logic        ready;
      logic [1:0]  d;
      logic        ev;
      logic        elk;
      logic        cq;
      logic [15:0] eq;   // expected LSB-first Q
   } vec_t;

   vec_t tab [10];

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // A word sent LSB-first lands bit-reversed per lane in the MSB-first instance.
   function automatic logic [15:0] msb_of(input logic [15:0] v);
      return {rev8(v[15:8]), rev8(v[7:0])};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk_state(input string name, input logic ev, input logic elk,
                            input logic eov, input logic cq, input logic [15:0] eq);
      chk({name, ".valid_l"},  {15'd0, valid_l},  {15'd0, ev});
      chk({name, ".valid_m"},  {15'd0, valid_m},  {15'd0, ev});
      chk({name, ".locked_l"}, {15'd0, locked_l}, {15'd0, elk});
      chk({name, ".locked_m"}, {15'd0, locked_m}, {15'd0, elk});
      chk({name, ".ovr_l"},    {15'd0, ovr_l},    {15'd0, eov});
      chk({name, ".ovr_m"},    {15'd0, ovr_m},    {15'd0, eov});
      if (cq) begin
         chk({name, ".q_l"}, q_l, eq);
         chk({name, ".q_m"}, q_m, msb_of(eq));
      end
   endtask

   task automatic step(input logic en_v, input logic sync_v, input logic [1:0] d_v);
      EN   = en_v;
      SYNC = sync_v;
      D    = d_v;
      @(posedge CK);
      #1;
   endtask

   // Send the first n bits of lane words w0/w1, LSB first; count cycles with VALID seen.
   task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1,
                            input logic first_sync, input int n, output int vseen);
      vseen = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, first_sync && (i == 0), {w1[i], w0[i]});
         if (valid_l) vseen++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          vs;
      int          pulses;
      logic [7:0]  a0, a1, wd;

      // lane0 stream 1,0,1,1,0,0,1,0 -> 8'h4D LSB-first, 8'h B2 MSB-first; lane1 zero
      tab[0] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[1] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[2] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[3] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[4] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[5] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[6] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 16'h0000};
      tab[7] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 16'h004D};
      tab[8] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000};
      tab[9] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000};

      // asynchronous reset before any clock edge
      #2 RST = 1'b1;
      #2;
      chk_state("rst_async", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      @(negedge CK);
      chk_state("rst_held", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      RST = 1'b0;

      // alignment and bit order
      for (int i = 0; i < 10; i++) begin
         READY = tab[i].ready;
         step(tab[i].en, tab[i].sync, tab[i].d);
         chk_state($sformatf("vec%0d", i), tab[i].ev, tab[i].elk, 1'b0, tab[i].cq, tab[i].eq);
         if (i == 7) chk("align_msb_b2", q_m, 16'h00B2);
      end

      // reset in the middle of a word
      READY = 1'b1;
      send_bits(8'h1F, 8'h1F, 1'b1, 5, vs);
      #2 RST = 1'b1;
      #1;
      chk_state("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      @(negedge CK);
      RST = 1'b0;
      step(1'b0, 1'b1, 2'b11);
      chk_state("hunt_sync_noen", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      send_bits(8'hA5, 8'h5A, 1'b0, 8, pulses);
      send_bits(8'hFF, 8'h00, 1'b0, 8, vs);
      chk("hunt_no_valid", 16'(pulses + vs), 16'd0);
      chk_state("hunt_idle", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

      // gapped EN, two lanes
      a0 = 8'hA5;
      a1 = 8'h3C;
      vs = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, i == 0, {a1[i], a0[i]});
         if (i < 7) begin
            if (valid_l || valid_m) vs++;
            step(1'b0, 1'b0, 2'b00);
            if (valid_l || valid_m) vs++;
         end
      end
      chk("gap_early_valid", 16'(vs), 16'd0);
      chk_state("gap_done", 1'b1, 1'b1, 1'b0, 1'b1, 16'h3CA5);
      chk("gap_msb_const", q_m, 16'h3CA5);
      step(1'b0, 1'b0, 2'b00);
      chk_state("gap_taken", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

      // backpressure and overrun
      READY = 1'b0;
      send_bits(8'h11, 8'hEE, 1'b1, 8, vs);
      chk_state("bp_first", 1'b1, 1'b1, 1'b0, 1'b1, 16'hEE11);
      send_bits(8'h22, 8'hDD, 1'b0, 8, vs);
      chk_state("bp_ovr", 1'b1, 1'b1, 1'b1, 1'b1, 16'hEE11);
      READY = 1'b1;
      step(1'b0, 1'b0, 2'b00);
      chk_state("bp_drain", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      CLR_OVR = 1'b1;
      step(1'b0, 1'b0, 2'b00);
      CLR_OVR = 1'b0;
      chk_state("bp_clr", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

      // overrun and clear on the same edge: set wins
      READY = 1'b0;
      send_bits(8'h33, 8'hCC, 1'b0, 8, vs);
      send_bits(8'h44, 8'hBB, 1'b0, 7, vs);
      CLR_OVR = 1'b1;
      step(1'b1, 1'b0, 2'b10);
      CLR_OVR = 1'b0;
      chk_state("ovr_set_wins", 1'b1, 1'b1, 1'b1, 1'b1, 16'hCC33);
      READY = 1'b1;
      CLR_OVR = 1'b1;
      step(1'b0, 1'b0, 2'b00);
      CLR_OVR = 1'b0;
      chk_state("ovr_cleared", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

      // READY arrives on the completion edge of the next word: no bubble, no overrun
      READY = 1'b0;
      send_bits(8'h5A, 8'hA5, 1'b1, 8, vs);
      chk_state("nb_first", 1'b1, 1'b1, 1'b0, 1'b1, 16'hA55A);
      send_bits(8'hC3, 8'h3C, 1'b0, 7, vs);
      READY = 1'b1;
      step(1'b1, 1'b0, 2'b01);
      chk_state("nb_second", 1'b1, 1'b1, 1'b0, 1'b1, 16'h3CC3);
      step(1'b0, 1'b0, 2'b00);
      chk_state("nb_taken", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

      // back-to-back words with continuous EN and READY=1
      pulses = 0;
      for (int w = 1; w <= 3; w++) begin
         wd = 8'(w);
         a1 = {wd[3:0], 4'h0};
         for (int i = 0; i < 8; i++) begin
            step(1'b1, (w == 1) && (i == 0), {a1[i], wd[i]});
            if (valid_l) pulses++;
            if (i == 7) chk_state($sformatf("b2b_w%0d", w), 1'b1, 1'b1, 1'b0, 1'b1, {a1, wd});
         end
      end
      step(1'b0, 1'b0, 2'b00);
      if (valid_l) pulses++;
      chk("b2b_pulses", 16'(pulses), 16'd3);
      chk_state("b2b_end", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

      // SYNC&EN after 3 bits restarts the frame
      send_bits(8'hFF, 8'hFF, 1'b1, 3, vs);
      send_bits(8'h96, 8'h69, 1'b1, 7, vs);
      chk("resync_early", 16'(vs), 16'd0);
      step(1'b1, 1'b0, 2'b01);
      chk_state("resync_done", 1'b1, 1'b1, 1'b0, 1'b1, 16'h6996);
      step(1'b0, 1'b0, 2'b00);

      // SYNC without EN in LOCK drops the partial word and zeroes the counter
      send_bits(8'hF0, 8'h0F, 1'b0, 4, vs);
      step(1'b0, 1'b1, 2'b11);
      chk_state("sync_noen", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      send_bits(8'h3A, 8'hC5, 1'b0, 7, vs);
      chk("sync_noen_early", 16'(vs), 16'd0);
      step(1'b1, 1'b0, 2'b10);
      chk_state("sync_noen_done", 1'b1, 1'b1, 1'b0, 1'b1, 16'hC53A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
